enc_pkt_framer: RTL and testbench
=================================

Name: enc_pkt_framer

Overview:
- Ingress stage directly upstream of top_encryption on the 64-bit packet datapath.
- Accepts the packet stream (data/ctrl/wr/rdy) and classifies every word:
  - module-header word: ctrl != 0 before the payload;
  - cleartext header payload: the first HDR_SKIP payload words;
  - cipher payload: everything after those.
- Buffers words in a small FIFO, honours downstream back-pressure, and emits each word with an o_enc tag so the encryptor transforms only cipher payload.

Parameters:
- FIFO_DEPTH, 8: FIFO entries; power of two, minimum 4.
- HDR_SKIP, 3: payload words per packet passed in clear (Ethernet/IP header).
- DATA_W, 64: datapath width; must be 4 x 16-bit cipher words.
- CTRL_W, 8: ctrl width.

Ports:
- clk  in  1  datapath clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  upstream word.
- in_ctrl  in  CTRL_W  upstream ctrl; 8'hFF = module header, 0 = payload, other nonzero = last word (byte-valid mask).
- in_wr  in  1  upstream write strobe.
- in_rdy  out  1  space available.
- out_data  out  DATA_W  word to top_encryption.in_data.
- out_ctrl  out  CTRL_W  ctrl to top_encryption.in_ctrl.
- out_enc  out  1  1 = word must be encrypted.
- out_wr  out  1  output valid strobe (one word per high cycle).
- out_rdy  in  1  downstream ready.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset values (async assert, sync deassert assumed at system level): out_data=0, out_ctrl=0, out_enc=0, out_wr=0, in_rdy=0 for the first cycle then 1, ovf=0. FIFO is empty, FSM is in IDLE, and the payload counter is 0.
- **Input classifier FSM** (evaluated on in_wr words only):
  - IDLE:
    - ctrl==8'hFF → MODHDR, tag 0.
    - ctrl==0 → PAYLOAD, cnt=1, tag 0 if HDR_SKIP>0.
    - other nonzero → single-word packet, tag 0, stay IDLE.
  - MODHDR:
    - ctrl==8'hFF → stay, tag 0.
    - ctrl==0 → PAYLOAD, cnt=1, tag (HDR_SKIP==0).
    - other nonzero → IDLE, tag 0.
  - PAYLOAD:
    - tag = (cnt >= HDR_SKIP); cnt saturates at HDR_SKIP.
    - ctrl==0 → stay.
    - ctrl nonzero and != 8'hFF → last word: tag as above, go to IDLE, cnt=0.
    - ctrl==8'hFF → protocol error: treat as a new packet start, go to MODHDR, tag 0.
- **FIFO**:
  - Stores {tag, ctrl, data} on in_wr when not full.
  - in_wr while full: word dropped, FSM not advanced, ovf set until reset.
- in_rdy is registered: 1 when occupancy <= FIFO_DEPTH-2 after the current cycle's write/read. This gives one cycle of slack for a write in flight.
- **Output**:
  - Pop when the FIFO is non-empty and (out_wr==0 or out_rdy==1).
  - Popped entry is registered onto out_*; out_wr=1.
  - out_wr held high with stable data while out_rdy==0.
  - out_wr drops the cycle after the last accepted word when the FIFO is empty.
- Latency: a word sampled on in_wr at edge k appears with out_wr=1 after edge k+1 when the FIFO was empty and out_rdy=1.
- Throughput: one word per cycle sustained.
- Simultaneous push and pop when full: push accepted (occupancy unchanged); no ovf.
- Pointer wrap: modulo FIFO_DEPTH, with an extra MSB for full/empty.
- Reset mid-packet: all state is cleared and the partial packet is lost. The next word is classified from IDLE.

Optional Feature:
- Macro ENC_FRAMER_STATS_EN.
- Defined:
  - adds outputs pkt_cnt[31:0] and enc_word_cnt[31:0], both wrapping, reset 0;
  - pkt_cnt increments on each output word with out_wr&&out_rdy whose ctrl is a last-word mask;
  - enc_word_cnt increments on each accepted word with out_enc=1.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package enc_pkg:
  - CTRL_MODHDR=8'hFF, CTRL_PAYLOAD=8'h00;
  - DATA_W/CTRL_W defaults;
  - state typedef {IDLE, MODHDR, PAYLOAD}.
- Sub-module enc_sync_fifo: parameterized width/depth, push/pop, full/empty, and count for the in_rdy threshold.
- Classifier FSM and output register stay in enc_pkt_framer.

Test Plan:
- Reset release, 1 module header (FF), 5 payload words (0), last word ctrl=8'h0F, out_rdy=1:
  - outputs appear 1 cycle after input in order;
  - out_enc sequence 0,0,0,0,1,1,1 (last word encrypted).
- HDR_SKIP=3, packet of 2 payload words with last ctrl=8'h80: all out_enc=0; FSM returns to IDLE; next packet classifies correctly.
- Back-pressure: out_rdy=0 for 12 cycles while streaming:
  - in_rdy falls once occupancy reaches 7;
  - out_data stays stable while held;
  - no loss on release;
  - ovf=0.
- Overflow: force in_wr while in_rdy=0 until full, then one extra write → that word dropped, ovf=1 and sticky.
- Full plus simultaneous push/pop for 20 cycles → occupancy constant, data order preserved, ovf=0.
- rst_n pulsed low mid-payload → outputs zero immediately; next packet starting with ctrl=0 tags first 3 words 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants and types for the encryption ingress framer.
//   CTRL_MODHDR / CTRL_PAYLOAD : ctrl codes for module-header and payload words
//   DATA_W_DEF / CTRL_W_DEF    : default datapath and ctrl widths
//   state_t                    : classifier states
//   cnt_width()                : width of the payload counter for a given skip
package enc_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CTRL_W_DEF = 8;

  localparam logic [7:0] CTRL_MODHDR  = 8'hFF;
  localparam logic [7:0] CTRL_PAYLOAD = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MODHDR  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  // Counter must hold values 0..skip; keep at least one bit so skip=0 still builds.
  function automatic int cnt_width(input int skip);
    int w;
    w = $clog2(skip + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/enc_pkt_framer_if.sv
// Packet stream bundle between the upstream source, the framer and top_encryption.
//   in_data/in_ctrl/in_wr  : upstream word, ctrl and write strobe
//   in_rdy                 : framer has space
//   out_data/out_ctrl      : word and ctrl towards the encryptor
//   out_enc                : word must be encrypted
//   out_wr/out_rdy         : output valid / downstream ready
// master = stream source and sink (test harness / neighbours), slave = framer.
interface enc_pkt_framer_if
  import enc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
);
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_wr;
  logic              in_rdy;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_enc;
  logic              out_wr;
  logic              out_rdy;

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_enc, out_wr
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_enc, out_wr
  );
endinterface

// File: rtl/enc_sync_fifo.sv
// Single-clock FIFO with extra pointer MSB for full/empty discrimination.
//   clk, rst_n  : clock, async active-low reset
//   push, wdata : write (caller guarantees space, or a pop in the same cycle)
//   pop, rdata  : read; rdata shows the head entry combinationally
//   full, empty : status
//   count       : current occupancy
module enc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Push and pop on a full FIFO touch the same slot; the head is read out
  // before the edge that overwrites it, so order is preserved.
  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/enc_pkt_framer.sv
// Ingress framer ahead of top_encryption: classifies each word as module header,
// cleartext header payload or cipher payload, buffers it and tags it with out_enc.
//   clk, rst_n   : datapath clock, async active-low reset
//   bus (slave)  : in_data/in_ctrl/in_wr/in_rdy upstream,
//                  out_data/out_ctrl/out_enc/out_wr/out_rdy downstream
//   ovf          : sticky overflow (a write arrived while full)
// Build option ENC_FRAMER_STATS_EN adds pkt_cnt and enc_word_cnt outputs.
//
// state   | meaning
// IDLE    | between packets
// MODHDR  | inside module-header words (ctrl = FF)
// PAYLOAD | inside payload; cnt counts words up to HDR_SKIP
module enc_pkt_framer
  import enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int HDR_SKIP   = 3,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CTRL_W     = CTRL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  enc_pkt_framer_if.slave      bus,
  output logic                 ovf
`ifdef ENC_FRAMER_STATS_EN
  ,
  output logic [31:0]          pkt_cnt,
  output logic [31:0]          enc_word_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = cnt_width(HDR_SKIP);
  localparam int EW = 1 + CTRL_W + DATA_W;

  localparam logic [CTRL_W-1:0] C_MOD     = CTRL_W'(CTRL_MODHDR);
  localparam logic [CTRL_W-1:0] C_PAY     = CTRL_W'(CTRL_PAYLOAD);
  localparam logic [CW-1:0]     SKIP      = CW'(HDR_SKIP);
  localparam logic              SKIP_ZERO = (HDR_SKIP == 0);
  localparam logic [AW:0]       RDY_LIMIT = (AW+1)'(FIFO_DEPTH - 2);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             tag;
  logic             is_mod, is_pay;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [AW:0]      occ, occ_nxt;
  logic [EW-1:0]    fifo_rd;

  assign is_mod = (bus.in_ctrl == C_MOD);
  assign is_pay = (bus.in_ctrl == C_PAY);

  // Output register can take a new entry when empty or being drained this cycle.
  assign pop  = !fifo_empty && (!bus.out_wr || bus.out_rdy);
  // A write on a full FIFO still goes in when the head leaves in the same cycle.
  assign push = bus.in_wr && (!fifo_full || pop);

  // Classifier only advances on words that actually enter the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (push) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, MODHDR: begin
        if (is_mod) begin
          state_nxt = MODHDR;
          cnt_nxt   = '0;
        end else if (is_pay) begin
          state_nxt = PAYLOAD;
          cnt_nxt   = CW'(1);
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      PAYLOAD: begin
        if (is_mod) begin
          state_nxt = MODHDR;
          cnt_nxt   = '0;
        end else if (is_pay) begin
          state_nxt = PAYLOAD;
          cnt_nxt   = (cnt >= SKIP) ? cnt : cnt + CW'(1);
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    tag = 1'b0;
    case (state)
      IDLE, MODHDR: tag = is_pay && SKIP_ZERO;
      PAYLOAD:      tag = !is_mod && (cnt >= SKIP);
      default:      tag = 1'b0;
    endcase
  end

  enc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({tag, bus.in_ctrl, bus.in_data}),
    .pop   (pop),
    .rdata (fifo_rd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

  assign occ_nxt = occ + (AW+1)'(push) - (AW+1)'(pop);

  // Registered threshold leaves one slot for a word already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.in_rdy <= 1'b0;
    else        bus.in_rdy <= (occ_nxt <= RDY_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovf <= 1'b0;
    else if (bus.in_wr && !push) ovf <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data <= '0;
      bus.out_ctrl <= '0;
      bus.out_enc  <= 1'b0;
      bus.out_wr   <= 1'b0;
    end else if (pop) begin
      {bus.out_enc, bus.out_ctrl, bus.out_data} <= fifo_rd;
      bus.out_wr <= 1'b1;
    end else if (bus.out_rdy) begin
      bus.out_wr <= 1'b0;
    end
  end

`ifdef ENC_FRAMER_STATS_EN
  logic out_acc;
  logic out_last;

  assign out_acc  = bus.out_wr && bus.out_rdy;
  assign out_last = (bus.out_ctrl != C_PAY) && (bus.out_ctrl != C_MOD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt      <= '0;
      enc_word_cnt <= '0;
    end else begin
      if (out_acc && out_last)    pkt_cnt      <= pkt_cnt + 32'd1;
      if (out_acc && bus.out_enc) enc_word_cnt <= enc_word_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_enc_pkt_framer.sv
module tb_enc_pkt_framer;
  import enc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ovf;
`ifdef ENC_FRAMER_STATS_EN
  logic [31:0] pkt_cnt;
  logic [31:0] enc_word_cnt;
`endif

  always #5 clk = ~clk;

  enc_pkt_framer_if #(.DATA_W(64), .CTRL_W(8)) bus ();

  enc_pkt_framer #(
    .FIFO_DEPTH (8),
    .HDR_SKIP   (3),
    .DATA_W     (64),
    .CTRL_W     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .ovf   (ovf)
`ifdef ENC_FRAMER_STATS_EN
    ,
    .pkt_cnt      (pkt_cnt),
    .enc_word_cnt (enc_word_cnt)
`endif
  );

  typedef struct packed {
    logic        enc;
    logic [7:0]  ctrl;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   spurious = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every accepted output word is compared against the hand-built expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_wr && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        spurious++;
      end else begin
        e = exp_q.pop_front();
        check_val("out_data", bus.out_data, e.data);
        check_val("out_ctrl", 64'(bus.out_ctrl), 64'(e.ctrl));
        check_val("out_enc",  64'(bus.out_enc),  64'(e.enc));
      end
    end
  end

  task automatic send(input logic [7:0] ctrl, input logic [63:0] data,
                      input logic enc, input logic acc);
    bus.in_wr   = 1'b1;
    bus.in_ctrl = ctrl;
    bus.in_data = data;
    if (acc) exp_q.push_back({enc, ctrl, data});
    @(posedge clk); #1;
    bus.in_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_wr) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val({tag, "_left"},     64'(exp_q.size()), 64'd0);
    check_val({tag, "_spurious"}, 64'(spurious),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;
    logic        held_v;
    int          sent;

    bus.in_wr   = 1'b0;
    bus.in_ctrl = '0;
    bus.in_data = '0;
    bus.out_rdy = 1'b1;

    // Asynchronous reset
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_out_wr",   64'(bus.out_wr),   64'd0);
    check_val("rst_out_data", bus.out_data,      64'd0);
    check_val("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check_val("rst_out_enc",  64'(bus.out_enc),  64'd0);
    check_val("rst_in_rdy",   64'(bus.in_rdy),   64'd0);
    check_val("rst_ovf",      64'(ovf),          64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rdy_first_cycle", 64'(bus.in_rdy), 64'd0);
    @(posedge clk); #1;
    check_val("rdy_after_reset", 64'(bus.in_rdy), 64'd1);

    // Header + 5 payload + last: tags 0,0,0,0,1,1,1 with one-cycle latency
    send(8'hFF, 64'h1111_0000_0000_0000, 1'b0, 1'b1);
    @(negedge clk);
    check_val("lat_early_wr", 64'(bus.out_wr), 64'd0);
    @(posedge clk); #1;
    check_val("lat_wr",   64'(bus.out_wr), 64'd1);
    check_val("lat_data", bus.out_data,    64'h1111_0000_0000_0000);
    send(8'h00, 64'h1111_0000_0000_0001, 1'b0, 1'b1);
    send(8'h00, 64'h1111_0000_0000_0002, 1'b0, 1'b1);
    send(8'h00, 64'h1111_0000_0000_0003, 1'b0, 1'b1);
    send(8'h00, 64'h1111_0000_0000_0004, 1'b1, 1'b1);
    send(8'h00, 64'h1111_0000_0000_0005, 1'b1, 1'b1);
    send(8'h0F, 64'h1111_0000_0000_0006, 1'b1, 1'b1);
    drain("t1");

    // Short packet stays clear, single-word packet, then a normal packet
    send(8'h00, 64'h2222_0000_0000_0001, 1'b0, 1'b1);
    send(8'h00, 64'h2222_0000_0000_0002, 1'b0, 1'b1);
    send(8'h80, 64'h2222_0000_0000_0003, 1'b0, 1'b1);
    send(8'h3C, 64'h2222_0000_0000_0004, 1'b0, 1'b1);
    send(8'hFF, 64'h2222_0000_0000_0005, 1'b0, 1'b1);
    send(8'h00, 64'h2222_0000_0000_0006, 1'b0, 1'b1);
    send(8'h00, 64'h2222_0000_0000_0007, 1'b0, 1'b1);
    send(8'h00, 64'h2222_0000_0000_0008, 1'b0, 1'b1);
    send(8'h00, 64'h2222_0000_0000_0009, 1'b1, 1'b1);
    send(8'h01, 64'h2222_0000_0000_000A, 1'b1, 1'b1);
    drain("t2");

    // Back-pressure for 12 cycles, writer honours in_rdy
    bus.out_rdy = 1'b0;
    sent   = 0;
    held   = '0;
    held_v = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.out_wr) begin
        if (!held_v) begin
          held   = bus.out_data;
          held_v = 1'b1;
        end else begin
          check_val("t3_hold_data", bus.out_data, held);
        end
      end
      if (bus.in_rdy) begin
        send((sent == 0) ? 8'hFF : 8'h00, 64'h3333_0000_0000_0000 + 64'(sent),
             (sent >= 4), 1'b1);
        sent++;
      end else begin
        idle(1);
      end
    end
    check_val("t3_sent",     64'(sent),       64'd8);
    check_val("t3_in_rdy",   64'(bus.in_rdy), 64'd0);
    check_val("t3_held_w0",  held,            64'h3333_0000_0000_0000);
    check_val("t3_ovf",      64'(ovf),        64'd0);
    bus.out_rdy = 1'b1;
    send(8'h0F, 64'h3333_0000_0000_00FF, 1'b1, 1'b1);
    drain("t3");

    // Fill to full, then push and pop together for 20 cycles
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 9; i++)
      send((i == 0) ? 8'hFF : 8'h00, 64'h5555_0000_0000_0000 + 64'(i), (i >= 4), 1'b1);
    check_val("t5_full_rdy", 64'(bus.in_rdy), 64'd0);
    check_val("t5_full_ovf", 64'(ovf),        64'd0);
    bus.out_rdy = 1'b1;
    for (int i = 9; i < 29; i++) begin
      send(8'h00, 64'h5555_0000_0000_0000 + 64'(i), 1'b1, 1'b1);
      check_val("t5_rdy", 64'(bus.in_rdy), 64'd0);
      check_val("t5_ovf", 64'(ovf),        64'd0);
    end
    send(8'h0F, 64'h5555_0000_0000_00FF, 1'b1, 1'b1);
    drain("t5");

    // Overflow: force writes past full, the dropped word does not move the FSM
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 9; i++)
      send(8'hFF, 64'h4444_0000_0000_0000 + 64'(i), 1'b0, 1'b1);
    check_val("t4_ovf_before", 64'(ovf), 64'd0);
    send(8'h00, 64'h4444_0000_DEAD_0000, 1'b0, 1'b0);
    check_val("t4_ovf_set", 64'(ovf), 64'd1);
    idle(3);
    check_val("t4_ovf_sticky", 64'(ovf), 64'd1);
    bus.out_rdy = 1'b1;
    send(8'h00, 64'h4444_0000_0000_0010, 1'b0, 1'b1);
    send(8'h00, 64'h4444_0000_0000_0011, 1'b0, 1'b1);
    send(8'h00, 64'h4444_0000_0000_0012, 1'b0, 1'b1);
    send(8'h01, 64'h4444_0000_0000_0013, 1'b1, 1'b1);
    drain("t4");
    check_val("t4_ovf_end", 64'(ovf), 64'd1);

    // Reset mid-payload clears everything; next packet starts from IDLE
    send(8'hFF, 64'h6666_0000_0000_0000, 1'b0, 1'b1);
    send(8'h00, 64'h6666_0000_0000_0001, 1'b0, 1'b1);
    send(8'h00, 64'h6666_0000_0000_0002, 1'b0, 1'b1);
    check_val("t6_pre_wr", 64'(bus.out_wr), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_val("t6_rst_wr",   64'(bus.out_wr),   64'd0);
    check_val("t6_rst_data", bus.out_data,      64'd0);
    check_val("t6_rst_ctrl", 64'(bus.out_ctrl), 64'd0);
    check_val("t6_rst_rdy",  64'(bus.in_rdy),   64'd0);
    check_val("t6_rst_ovf",  64'(ovf),          64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check_val("t6_rdy", 64'(bus.in_rdy), 64'd1);
    send(8'h00, 64'h7777_0000_0000_0001, 1'b0, 1'b1);
    send(8'h00, 64'h7777_0000_0000_0002, 1'b0, 1'b1);
    send(8'h00, 64'h7777_0000_0000_0003, 1'b0, 1'b1);
    send(8'h00, 64'h7777_0000_0000_0004, 1'b1, 1'b1);
    send(8'h07, 64'h7777_0000_0000_0005, 1'b1, 1'b1);
    drain("t6");
    check_val("t6_ovf_end", 64'(ovf), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
